// File: rtl/p1v_reset_pkg.sv
// Shared types for the p1v reset sequencer: FSM states, reset causes and small helpers.
package p1v_reset_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STRETCH   = 2'd1,
    RUN       = 2'd2,
    ASSERT    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'd0,
    CAUSE_KEY  = 2'd1,
    CAUSE_PLUG = 2'd2,
    CAUSE_PLL  = 2'd3
  } cause_t;

  // Idle level of the active-low reset sources (key and Prop-plug).
  localparam logic SRC_RELEASED = 1'b1;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_filter.sv
// Two-flop synchronizer followed by a symmetric stable-count filter for an active-low source.
module sync_filter
  import p1v_reset_pkg::*;
#(
  parameter int unsigned N     = 16,
  parameter int unsigned CNT_W = 21
) (
  input  logic clock_160,
  input  logic inp_resn,
  input  logic raw,
  output logic filtered
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(N - 1);

  logic [1:0]       sync_q;
  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter tracks consecutive cycles where the synchronized input disagrees with the output.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CntLast) begin
        filt_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock_160 or negedge inp_resn) begin
    if (!inp_resn) begin
      sync_q <= {2{SRC_RELEASED}};
      filt_q <= SRC_RELEASED;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], raw};
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filtered = filt_q;

endmodule

// File: rtl/reset_sequencer.sv
// Merges key, Prop-plug and PLL-lock into one stretched, registered active-low core reset,
// and records the cause and a saturating count of core resets.
module reset_sequencer
  import p1v_reset_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1600000,
  parameter int unsigned PLUG_FILTER     = 16,
  parameter int unsigned STRETCH_CYCLES  = 16000,
  parameter int unsigned CNT_W           = 21
) (
  input  logic       clock_160,
  input  logic       inp_resn,
  input  logic       key_n,
  input  logic       plug_resn,
  input  logic       pll_locked,
  output logic       core_resn,
  output logic [1:0] reset_cause,
  output logic [7:0] reset_count
);

  localparam logic [CNT_W-1:0] StrLast = CNT_W'(STRETCH_CYCLES - 1);

  logic             key_f, plug_f, lock_s;
  logic [1:0]       lock_sync_q;
  state_t           state_q, state_d;
  cause_t           cause_q, cause_d;
  logic [CNT_W-1:0] str_cnt_q, str_cnt_d;
  logic [7:0]       count_q, count_d;
  logic             core_resn_q, core_resn_d;

  sync_filter #(
    .N     (DEBOUNCE_CYCLES),
    .CNT_W (CNT_W)
  ) u_key_filter (
    .clock_160 (clock_160),
    .inp_resn  (inp_resn),
    .raw       (key_n),
    .filtered  (key_f)
  );

  sync_filter #(
    .N     (PLUG_FILTER),
    .CNT_W (CNT_W)
  ) u_plug_filter (
    .clock_160 (clock_160),
    .inp_resn  (inp_resn),
    .raw       (plug_resn),
    .filtered  (plug_f)
  );

  assign lock_s = lock_sync_q[1];

  always_comb begin
    state_d   = state_q;
    str_cnt_d = str_cnt_q;
    cause_d   = cause_q;
    count_d   = count_q;
    case (state_q)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d   = STRETCH;
          str_cnt_d = '0;
        end
      end
      STRETCH: begin
        // Re-assertion here is the same episode, so the cause stays untouched.
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (!key_f || !plug_f) begin
          state_d = ASSERT;
        end else if (str_cnt_q == StrLast) begin
          state_d = RUN;
        end else begin
          str_cnt_d = str_cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cause_d = CAUSE_PLL;
          count_d = sat_inc8(count_q);
        end else if (!key_f) begin
          state_d = ASSERT;
          cause_d = CAUSE_KEY;
          count_d = sat_inc8(count_q);
        end else if (!plug_f) begin
          state_d = ASSERT;
          cause_d = CAUSE_PLUG;
          count_d = sat_inc8(count_q);
        end
      end
      ASSERT: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (key_f && plug_f) begin
          state_d   = STRETCH;
          str_cnt_d = '0;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Decoded from the next state so the registered output is glitch-free and aligned with RUN.
  assign core_resn_d = (state_d == RUN);

  always_ff @(posedge clock_160 or negedge inp_resn) begin
    if (!inp_resn) begin
      lock_sync_q <= 2'b00;
      state_q     <= WAIT_LOCK;
      cause_q     <= CAUSE_POR;
      str_cnt_q   <= '0;
      count_q     <= '0;
      core_resn_q <= 1'b0;
    end else begin
      lock_sync_q <= {lock_sync_q[0], pll_locked};
      state_q     <= state_d;
      cause_q     <= cause_d;
      str_cnt_q   <= str_cnt_d;
      count_q     <= count_d;
      core_resn_q <= core_resn_d;
    end
  end

  assign core_resn   = core_resn_q;
  assign reset_cause = cause_q;
  assign reset_count = count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed plus randomized bench for reset_sequencer against a run-length behavioural model.
module tb_reset_sequencer;

  localparam int DB = 8;
  localparam int PF = 3;
  localparam int SC = 4;
  localparam int CW = 8;

  logic       clock_160 = 1'b0;
  logic       inp_resn;
  logic       key_n;
  logic       plug_resn;
  logic       pll_locked;
  logic       core_resn;
  logic [1:0] reset_cause;
  logic [7:0] reset_count;

  int n_assert = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  always #5 clock_160 = ~clock_160;

  reset_sequencer #(
    .DEBOUNCE_CYCLES (DB),
    .PLUG_FILTER     (PF),
    .STRETCH_CYCLES  (SC),
    .CNT_W           (CW)
  ) dut (
    .clock_160   (clock_160),
    .inp_resn    (inp_resn),
    .key_n       (key_n),
    .plug_resn   (plug_resn),
    .pll_locked  (pll_locked),
    .core_resn   (core_resn),
    .reset_cause (reset_cause),
    .reset_count (reset_count)
  );

  // Reference model: synchronizer delay lines, disagreement-run filters, and a release rule
  // expressed as "lock and sources have both been good for long enough".
  logic [1:0] m_ks, m_ps, m_ls;
  logic       m_kf, m_pf;
  int         m_kcnt, m_pcnt, m_lock_run, m_src_run, m_count;
  logic       m_run;
  logic [1:0] m_cause;
  int         m_lr_n, m_sr_n;

  function automatic int run_next(input logic good, input int run);
    return good ? ((run < 100000) ? run + 1 : run) : 0;
  endfunction

  always_comb begin
    m_lr_n = run_next(m_ls[1], m_lock_run);
    m_sr_n = run_next(m_kf && m_pf, m_src_run);
  end

  always @(posedge clock_160 or negedge inp_resn) begin
    if (!inp_resn) begin
      m_ks       <= 2'b11;
      m_ps       <= 2'b11;
      m_ls       <= 2'b00;
      m_kf       <= 1'b1;
      m_pf       <= 1'b1;
      m_kcnt     <= 0;
      m_pcnt     <= 0;
      m_lock_run <= 0;
      m_src_run  <= 0;
      m_run      <= 1'b0;
      m_cause    <= 2'd0;
      m_count    <= 0;
    end else begin
      m_ks <= {m_ks[0], key_n};
      m_ps <= {m_ps[0], plug_resn};
      m_ls <= {m_ls[0], pll_locked};
      if (m_ks[1] != m_kf) begin
        if (m_kcnt + 1 == DB) begin
          m_kf   <= m_ks[1];
          m_kcnt <= 0;
        end else m_kcnt <= m_kcnt + 1;
      end else m_kcnt <= 0;
      if (m_ps[1] != m_pf) begin
        if (m_pcnt + 1 == PF) begin
          m_pf   <= m_ps[1];
          m_pcnt <= 0;
        end else m_pcnt <= m_pcnt + 1;
      end else m_pcnt <= 0;
      m_lock_run <= m_lr_n;
      m_src_run  <= m_sr_n;
      if (m_run) begin
        if (!(m_ls[1] && m_kf && m_pf)) begin
          m_run   <= 1'b0;
          m_cause <= !m_ls[1] ? 2'd3 : (!m_kf ? 2'd1 : 2'd2);
          m_count <= (m_count < 255) ? m_count + 1 : 255;
        end
      end else if (m_lr_n >= SC + 1 &&
                   (m_sr_n >= SC + 1 || (m_sr_n == SC && m_lr_n == SC + 1))) begin
        // Sources are ignored on the cycle lock first arrives, hence the S/S+1 pairing.
        m_run <= 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clock_160) begin
    if (check_en) begin
      chk("model_core_resn", {31'd0, core_resn}, {31'd0, m_run});
      chk("model_cause", {30'd0, reset_cause}, {30'd0, m_cause});
      chk("model_count", {24'd0, reset_count}, m_count);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clock_160);
  endtask

  // Returns the number of rising edges until core_resn equals val, or -1 on timeout.
  task automatic wait_core(input logic val, input int budget, output int lat);
    lat = 0;
    do begin
      @(negedge clock_160);
      lat++;
    end while (core_resn !== val && lat < budget);
    if (core_resn !== val) lat = -1;
  endtask

  task automatic hold_check(input string tag, input int n, input logic val);
    int bad;
    bad = 0;
    repeat (n) begin
      @(negedge clock_160);
      if (core_resn !== val) bad++;
    end
    chk(tag, bad, 0);
  endtask

  initial begin
    int lat;
    int bad;
    inp_resn   = 1'b0;
    key_n      = 1'b1;
    plug_resn  = 1'b1;
    pll_locked = 1'b0;
    cycles(3);
    chk("rst_core", {31'd0, core_resn}, 0);
    chk("rst_cause", {30'd0, reset_cause}, 0);
    chk("rst_count", {24'd0, reset_count}, 0);
    check_en = 1'b1;

    // Power-up
    inp_resn = 1'b1;
    hold_check("nolock_core_low", 10, 1'b0);
    pll_locked = 1'b1;
    wait_core(1'b1, 50, lat);
    chk("lock_release_lat", lat, 7);
    chk("por_cause", {30'd0, reset_cause}, 0);
    chk("por_count", {24'd0, reset_count}, 0);

    // Key bounce then hold
    for (int i = 0; i < 8; i++) begin
      key_n = ~key_n;
      hold_check("bounce_core_high", 5, 1'b1);
    end
    key_n = 1'b0;
    wait_core(1'b0, 50, lat);
    chk("key_assert_lat", lat, 11);
    chk("key_cause", {30'd0, reset_cause}, 1);
    chk("key_count", {24'd0, reset_count}, 1);
    key_n = 1'b1;
    wait_core(1'b1, 60, lat);
    chk("key_release_lat", lat, 15);

    // Plug glitch, then a real plug pulse
    plug_resn = 1'b0;
    cycles(2);
    plug_resn = 1'b1;
    hold_check("plug_glitch_core_high", 12, 1'b1);
    plug_resn = 1'b0;
    cycles(5);
    chk("plug_core_pre", {31'd0, core_resn}, 1);
    plug_resn = 1'b1;
    wait_core(1'b0, 5, lat);
    chk("plug_assert_lat", lat, 1);
    chk("plug_cause", {30'd0, reset_cause}, 2);
    wait_core(1'b1, 30, lat);
    chk("plug_release_lat", lat, 9);

    // Key and plug filtered low on the same edge
    key_n = 1'b0;
    cycles(DB - PF);
    plug_resn = 1'b0;
    wait_core(1'b0, 20, lat);
    chk("simul_lat", lat, 6);
    chk("simul_cause", {30'd0, reset_cause}, 1);
    chk("simul_count", {24'd0, reset_count}, 3);
    key_n = 1'b1;
    hold_check("plug_holds_core", 30, 1'b0);
    plug_resn = 1'b1;
    wait_core(1'b1, 30, lat);
    chk("simul_release_lat", lat, 10);

    // One-cycle lock loss in RUN
    pll_locked = 1'b0;
    cycles(1);
    pll_locked = 1'b1;
    wait_core(1'b0, 10, lat);
    chk("lock_loss_lat", lat, 2);
    chk("lock_loss_cause", {30'd0, reset_cause}, 3);
    chk("lock_loss_count", {24'd0, reset_count}, 4);
    wait_core(1'b1, 30, lat);
    chk("relock_lat", lat, 5);

    // Lock loss during STRETCH keeps the key cause
    key_n = 1'b0;
    wait_core(1'b0, 30, lat);
    key_n = 1'b1;
    cycles(11);
    pll_locked = 1'b0;
    cycles(2);
    pll_locked = 1'b1;
    chk("stretch_lockloss_core", {31'd0, core_resn}, 0);
    wait_core(1'b1, 40, lat);
    chk("stretch_lockloss_cause", {30'd0, reset_cause}, 1);
    chk("stretch_lockloss_count", {24'd0, reset_count}, 5);

    // Saturation
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      key_n = 1'b0;
      wait_core(1'b0, 40, lat);
      if (lat < 0) bad++;
      key_n = 1'b1;
      wait_core(1'b1, 40, lat);
      if (lat < 0) bad++;
    end
    chk("sat_loop_timeouts", bad, 0);
    chk("sat_count", {24'd0, reset_count}, 255);

    // Async reset mid-STRETCH
    key_n = 1'b0;
    wait_core(1'b0, 40, lat);
    key_n = 1'b1;
    cycles(12);
    #2;
    inp_resn = 1'b0;
    #1;
    chk("async_stretch_core", {31'd0, core_resn}, 0);
    chk("async_stretch_cause", {30'd0, reset_cause}, 0);
    chk("async_stretch_count", {24'd0, reset_count}, 0);
    @(negedge clock_160);
    inp_resn = 1'b1;
    wait_core(1'b1, 20, lat);
    chk("async_relock_lat", lat, 7);

    // Async reset from RUN drops core_resn without a clock edge
    #2;
    inp_resn = 1'b0;
    #1;
    chk("async_run_core", {31'd0, core_resn}, 0);
    @(negedge clock_160);
    inp_resn = 1'b1;

    // Randomized phase, checked by the model every cycle
    for (int i = 0; i < 250; i++) begin
      key_n      = ($urandom_range(0, 4) != 0);
      plug_resn  = ($urandom_range(0, 4) != 0);
      pll_locked = ($urandom_range(0, 9) != 0);
      cycles(int'($urandom_range(1, 20)));
    end
    key_n      = 1'b1;
    plug_resn  = 1'b1;
    pll_locked = 1'b1;
    wait_core(1'b1, 60, lat);
    chk("random_final_release", {31'd0, core_resn}, 1);

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
